// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, engine states, fixed addresses.
package sdram_pkg;
  // {CS,RAS,CAS,WE}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [11:0] PRE_ADDR = 12'h400;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_RD   = 5'b01000,
    S_PRE  = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    PK_DONE = 2'd0,
    PK_INTR = 2'd1,
    PK_ROW  = 2'd2
  } pre_kind_t;
endpackage

// File: rtl/sdram_read_if.sv
// Read engine bus: arbiter handshake, SDRAM command/address, DQ input and captured data.
interface sdram_read_if;
  logic        rd_trig;
  logic        rd_en;
  logic        ref_req;
  logic        rd_req;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  bank_addr;
  logic [15:0] sdram_dq;
  logic [15:0] rd_data;
  logic        rd_data_vld;

  modport master (
    input  rd_trig, rd_en, ref_req, sdram_dq,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, bank_addr, rd_data, rd_data_vld
  );
  modport slave (
    output rd_trig, rd_en, ref_req, sdram_dq,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, bank_addr, rd_data, rd_data_vld
  );
endinterface

// File: rtl/sdram_rd_capture.sv
// Read data capture: READ-issue marks shifted through a CL-aligned pipe open a 4-word DQ window.
module sdram_rd_capture #(
  parameter int CL = 3
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        rd_issue,
  input  logic [15:0] sdram_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld,
  output logic        pipe_empty
);
  localparam int STAGES = CL + 3;

  logic [STAGES:0] vld_pipe;
  logic            in_window;

  // rd_issue leads the registered READ command by one cycle, so DQ of the
  // burst is on the bus while the mark sits in stages CL..CL+3.
  assign in_window  = |vld_pipe[STAGES:CL];
  assign pipe_empty = ~|vld_pipe;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vld_pipe    <= '0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], rd_issue};
      rd_data_vld <= in_window;
      if (in_window) rd_data <= sdram_dq;
    end
  end
endmodule

// File: rtl/sdram_read.sv
// SDRAM read engine: arbitrates for the bus, walks bank 0 rows in 4-word READ bursts,
// yields to refresh at burst boundaries and resumes at the first unread burst.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int CL       = 3,
  parameter int T_RCD    = 4,
  parameter int T_RP     = 4,
  parameter int LAST_ROW = 2
) (
  input logic          sclk,
  input logic          s_rst_n,
  sdram_read_if.master bus
);
  state_t    state;
  pre_kind_t pre_kind;
  logic [3:0]  cnt;
  logic [1:0]  burst_cnt;
  logic [11:0] row;
  logic [8:0]  col;
  logic        rd_issue, pipe_empty, row_end, last_burst;

  assign bus.rd_req    = (state == S_REQ);
  assign bus.bank_addr = 2'b00;
  assign rd_issue      = (state == S_RD) && (burst_cnt == 2'd0);
  assign row_end       = (col == 9'd508);
  assign last_burst    = row_end && (row == 12'(LAST_ROW));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state           <= S_IDLE;
      pre_kind        <= PK_DONE;
      cnt             <= '0;
      burst_cnt       <= '0;
      row             <= '0;
      col             <= '0;
      bus.rd_cmd      <= CMD_NOP;
      bus.rd_addr     <= '0;
      bus.flag_rd_end <= 1'b0;
    end else begin
      bus.rd_cmd      <= CMD_NOP;
      bus.rd_addr     <= '0;
      bus.flag_rd_end <= 1'b0;
      case (state)
        S_IDLE: if (bus.rd_trig) state <= S_REQ;
        S_REQ: if (bus.rd_en) begin
          state <= S_ACT;
          cnt   <= '0;
        end
        S_ACT: begin
          if (cnt == 4'd0) begin
            bus.rd_cmd  <= CMD_ACT;
            bus.rd_addr <= row;
          end
          if (cnt == 4'(T_RCD - 1)) begin
            state     <= S_RD;
            cnt       <= '0;
            burst_cnt <= '0;
          end else cnt <= cnt + 4'd1;
        end
        S_RD: begin
          burst_cnt <= burst_cnt + 2'd1;
          if (burst_cnt == 2'd0) begin
            bus.rd_cmd  <= CMD_RD;
            bus.rd_addr <= {3'b000, col};
          end
          if (burst_cnt == 2'd3) begin
            col <= col + 9'd4;
            if (last_burst) begin
              state    <= S_PRE;
              pre_kind <= PK_DONE;
              row      <= '0;
              col      <= '0;
            end else begin
              // Row advances even when refresh wins, so a resume lands on the next row.
              if (row_end) row <= row + 12'd1;
              if (bus.ref_req) begin
                state    <= S_PRE;
                pre_kind <= PK_INTR;
              end else if (row_end) begin
                state    <= S_PRE;
                pre_kind <= PK_ROW;
              end
            end
          end
        end
        S_PRE: begin
          if (cnt == 4'd0) begin
            bus.rd_cmd  <= CMD_PRE;
            bus.rd_addr <= PRE_ADDR;
          end
          if (cnt != 4'hf) cnt <= cnt + 4'd1;
          // Hold the bus until in-flight burst data has been captured.
          if (cnt >= 4'(T_RP - 1) && pipe_empty) begin
            cnt <= '0;
            case (pre_kind)
              PK_DONE: begin
                state           <= S_IDLE;
                bus.flag_rd_end <= 1'b1;
              end
              PK_INTR: begin
                state           <= S_REQ;
                bus.flag_rd_end <= 1'b1;
              end
              default: state <= S_ACT;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sdram_rd_capture #(.CL(CL)) u_cap (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .rd_issue    (rd_issue),
    .sdram_dq    (bus.sdram_dq),
    .rd_data     (bus.rd_data),
    .rd_data_vld (bus.rd_data_vld),
    .pipe_empty  (pipe_empty)
  );
endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: a CL=3/3-row engine under directed flow, plus a CL=2/1-row engine
// free-running; both checked against an SDRAM DQ model and an expected word stream.
module tb_sdram_read;
  import sdram_pkg::*;

  localparam int CL0 = 3, CL1 = 2, T_RCD = 4, T_RP = 4;
  localparam int TOT0 = 3 * 512, TOT1 = 512;

  logic sclk = 1'b0;
  logic s_rst_n;
  always #5 sclk = ~sclk;

  sdram_read_if bus0();
  sdram_read_if bus1();

  sdram_read #(.CL(CL0), .T_RCD(T_RCD), .T_RP(T_RP), .LAST_ROW(2)) dut0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .bus(bus0.master));
  sdram_read #(.CL(CL1), .T_RCD(T_RCD), .T_RP(T_RP), .LAST_ROW(0)) dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .bus(bus1.master));

  int checks = 0, errors = 0;
  int cyc = 16;
  logic [15:0] salt;
  bit h_rd [2][16];
  int h_row [2][16];
  int h_col [2][16];
  int open_row [2];
  int pos [2];
  int xfers [2];
  int flags [2];
  bit pflag [2];
  int a, r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word stored at (row, col) in the modelled SDRAM; unique for all 1536 locations.
  function automatic logic [15:0] word(input int rw, input int cl);
    return 16'((rw * 512 + cl) * 40503) ^ salt;
  endfunction

  // Per-cycle SDRAM model and stream scoreboard for both engines.
  task automatic mon();
    logic [3:0] cmd; logic [11:0] addr; logic vld, flg; logic [15:0] dat, dq;
    int cl, tot, slot; bit ev;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        cmd = bus0.rd_cmd; addr = bus0.rd_addr; vld = bus0.rd_data_vld;
        flg = bus0.flag_rd_end; dat = bus0.rd_data; cl = CL0; tot = TOT0;
      end else begin
        cmd = bus1.rd_cmd; addr = bus1.rd_addr; vld = bus1.rd_data_vld;
        flg = bus1.flag_rd_end; dat = bus1.rd_data; cl = CL1; tot = TOT1;
      end
      dq = 16'($urandom);
      if (!s_rst_n) begin
        for (int i = 0; i < 16; i++) h_rd[d][i] = 1'b0;
        pos[d] = 0;
        pflag[d] = 1'b0;
      end else begin
        slot = cyc % 16;
        if (cmd == CMD_ACT) open_row[d] = int'(addr);
        h_rd[d][slot]  = (cmd == CMD_RD);
        h_row[d][slot] = open_row[d];
        h_col[d][slot] = int'(addr[8:0]);
        for (int k = 0; k < 4; k++) begin
          slot = (cyc - cl - k) % 16;
          if (h_rd[d][slot]) dq = word(h_row[d][slot], h_col[d][slot] + k);
        end
        ev = 1'b0;
        for (int k = 1; k <= 4; k++) if (h_rd[d][(cyc - cl - k) % 16]) ev = 1'b1;
        check($sformatf("vld_timing_dut%0d", d), 32'(vld), 32'(ev));
        if (vld) begin
          check($sformatf("rd_data_dut%0d_word%0d", d, pos[d]), 32'(dat),
                32'(word(pos[d] / 512, pos[d] % 512)));
          pos[d]++;
          if (pos[d] == tot) begin pos[d] = 0; xfers[d]++; end
        end
        if (flg) begin
          check($sformatf("flag_one_cycle_dut%0d", d), 32'(pflag[d]), 0);
          flags[d]++;
        end
        pflag[d] = flg;
      end
      if (d == 0) bus0.sdram_dq = dq; else bus1.sdram_dq = dq;
    end
  endtask

  task automatic tick();
    @(posedge sclk); #1;
    mon();
  endtask

  task automatic set_trig(input logic v);
    bus0.rd_trig = v;
    bus1.rd_trig = v;
  endtask

  task automatic wait_read(input int col, input int budget);
    int n = 0;
    while (!(bus0.rd_cmd === CMD_RD && bus0.rd_addr === 12'(col)) && n < budget) begin
      tick(); n++;
    end
    check($sformatf("reach_read_col%0d", col), 32'(n < budget), 1);
  endtask

  task automatic wait_nonnop(input int budget);
    int n = 0;
    while (bus0.rd_cmd === CMD_NOP && n < budget) begin tick(); n++; end
    check("reach_command", 32'(n < budget), 1);
  endtask

  task automatic wait_flag(input int budget);
    int n = 0;
    while (bus0.flag_rd_end !== 1'b1 && n < budget) begin tick(); n++; end
    check("reach_flag_rd_end", 32'(n < budget), 1);
  endtask

  task automatic grant();
    bus0.rd_en = 1'b1; tick(); bus0.rd_en = 1'b0;
  endtask

  initial begin
    salt = 16'($urandom);
    set_trig(1'b0);
    bus0.rd_en = 1'b0; bus0.ref_req = 1'b0; bus0.sdram_dq = '0;
    bus1.rd_en = 1'b1; bus1.ref_req = 1'b0; bus1.sdram_dq = '0;
    s_rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_cmd", 32'(bus0.rd_cmd), 32'(CMD_NOP));
    check("rst_addr", 32'(bus0.rd_addr), 0);
    check("rst_data", 32'(bus0.rd_data), 0);
    check("rst_vld", 32'(bus0.rd_data_vld), 0);
    check("rst_flag", 32'(bus0.flag_rd_end), 0);
    check("rst_req", 32'(bus0.rd_req), 0);
    check("rst_cmd_dut1", 32'(bus1.rd_cmd), 32'(CMD_NOP));
    s_rst_n = 1'b1;
    repeat ($urandom_range(2, 6)) tick();

    // Full transfer: handshake, ACT/READ timing, row crossing, ref_req on final burst.
    set_trig(1'b1); tick(); set_trig(1'b0);
    check("req_after_trig", 32'(bus0.rd_req), 1);
    tick();
    check("req_wait_grant", 32'(bus0.rd_req), 1);
    grant();
    check("req_drop_in_act", 32'(bus0.rd_req), 0);
    check("nop_before_act", 32'(bus0.rd_cmd), 32'(CMD_NOP));
    tick();
    check("act_cmd", 32'(bus0.rd_cmd), 32'(CMD_ACT));
    check("act_row0", 32'(bus0.rd_addr), 0);
    check("bank_addr", 32'(bus0.bank_addr), 0);
    a = cyc;
    wait_read(0, 16);
    check("t_rcd", 32'(cyc - a), T_RCD);
    r = cyc;
    wait_read(4, 8);
    check("read_spacing", 32'(cyc - r), 4);
    wait_read(508, 600);
    repeat (4) tick();
    check("row_end_pre", 32'(bus0.rd_cmd), 32'(CMD_PRE));
    check("row_end_pre_addr", 32'(bus0.rd_addr), 32'(PRE_ADDR));
    tick(); wait_nonnop(20);
    check("row1_act", 32'(bus0.rd_cmd), 32'(CMD_ACT));
    check("row1_addr", 32'(bus0.rd_addr), 1);
    a = cyc;
    tick(); wait_nonnop(20);
    check("row1_read", 32'(bus0.rd_cmd), 32'(CMD_RD));
    check("row1_col0", 32'(bus0.rd_addr), 0);
    check("row1_t_rcd", 32'(cyc - a), T_RCD);
    tick(); wait_read(508, 600);
    tick(); wait_read(508, 600);
    bus0.ref_req = 1'b1;
    repeat (4) tick();
    check("done_pre", 32'(bus0.rd_cmd), 32'(CMD_PRE));
    check("done_pre_addr", 32'(bus0.rd_addr), 32'(PRE_ADDR));
    wait_flag(20);
    check("done_to_idle", 32'(bus0.rd_req), 0);
    check("xfer1_complete", 32'(xfers[0]), 1);
    check("xfer1_no_extra", 32'(pos[0]), 0);
    bus0.ref_req = 1'b0;
    tick();
    check("flag_cleared", 32'(bus0.flag_rd_end), 0);
    repeat (10) tick();
    check("idle_stays", 32'(bus0.rd_req), 0);
    check("idle_nop", 32'(bus0.rd_cmd), 32'(CMD_NOP));
    check("one_flag", 32'(flags[0]), 1);

    // Refresh interrupt at col 100 with rd_trig held high throughout.
    set_trig(1'b1); tick();
    check("req2", 32'(bus0.rd_req), 1);
    repeat ($urandom_range(0, 3)) tick();
    grant(); tick();
    check("act2_row0", 32'(bus0.rd_addr), 0);
    wait_read(100, 200);
    bus0.ref_req = 1'b1;
    repeat (3) tick();
    check("no_read_after_intr", 32'(bus0.rd_cmd), 32'(CMD_NOP));
    tick();
    check("intr_pre", 32'(bus0.rd_cmd), 32'(CMD_PRE));
    check("intr_pre_addr", 32'(bus0.rd_addr), 32'(PRE_ADDR));
    wait_flag(20);
    check("intr_to_req", 32'(bus0.rd_req), 1);
    bus0.ref_req = 1'b0;
    repeat ($urandom_range(2, 8)) tick();
    check("req_holds", 32'(bus0.rd_req), 1);
    grant(); tick();
    check("resume_act", 32'(bus0.rd_cmd), 32'(CMD_ACT));
    check("resume_row", 32'(bus0.rd_addr), 0);
    tick(); wait_nonnop(10);
    check("resume_read", 32'(bus0.rd_cmd), 32'(CMD_RD));
    check("resume_col104", 32'(bus0.rd_addr), 104);
    wait_read(200, 600);
    set_trig(1'b0);
    wait_flag(2000);
    check("xfer2_done_idle", 32'(bus0.rd_req), 0);
    check("xfer2_complete", 32'(xfers[0]), 2);
    check("xfer2_no_extra", 32'(pos[0]), 0);

    // Reset mid-burst, then a clean restart from row 0, col 0.
    set_trig(1'b1); tick(); set_trig(1'b0);
    grant();
    wait_read(40, 600);
    tick(); tick();
    #1 s_rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", 32'(bus0.rd_cmd), 32'(CMD_NOP));
    check("mid_rst_addr", 32'(bus0.rd_addr), 0);
    check("mid_rst_data", 32'(bus0.rd_data), 0);
    check("mid_rst_vld", 32'(bus0.rd_data_vld), 0);
    check("mid_rst_flag", 32'(bus0.flag_rd_end), 0);
    check("mid_rst_req", 32'(bus0.rd_req), 0);
    tick(); tick();
    s_rst_n = 1'b1;
    repeat (12) begin
      tick();
      check("no_vld_after_rst", 32'(bus0.rd_data_vld), 0);
    end
    set_trig(1'b1); tick(); set_trig(1'b0);
    grant(); tick();
    check("restart_act", 32'(bus0.rd_cmd), 32'(CMD_ACT));
    check("restart_row0", 32'(bus0.rd_addr), 0);
    tick(); wait_nonnop(10);
    check("restart_read", 32'(bus0.rd_cmd), 32'(CMD_RD));
    check("restart_col0", 32'(bus0.rd_addr), 0);
    wait_flag(2000);
    check("xfer3_complete", 32'(xfers[0]), 3);
    check("xfer3_no_extra", 32'(pos[0]), 0);
    check("cl2_engine_transferred", 32'(xfers[1] >= 1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
